// File: rtl/fifo_pll_reset_ctrl.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses PLL reset,
// waits for a stable synchronized lock, and holds downstream logic in reset until then.
module fifo_pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 133000,
  parameter int CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked_in,
  output logic             pll_rst_out,
  output logic             sys_rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [1:0]       o_dbg_state
);

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                          RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int TW     = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ASSERT    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           r_state;
  logic [TW-1:0]    r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic [CNT_W-1:0] r_lock_loss;
  logic [CNT_W-1:0] r_timeout;
  logic             w_locked_sync;

  assign w_locked_sync = r_sync2;

  // Outputs are only rewritten on transitions, so they always decode the state just entered.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= S_ASSERT;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_loss <= '0;
      r_timeout   <= '0;
    end else begin
      r_sync1 <= pll_locked_in;
      r_sync2 <= r_sync1;
      case (r_state)
        S_ASSERT: begin
          if (r_cnt == PULSE_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_sync) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state   <= S_ASSERT;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_timeout != '1) r_timeout <= r_timeout + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_locked_sync) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!w_locked_sync) begin
            r_state   <= S_ASSERT;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            if (r_lock_loss != '1) r_lock_loss <= r_lock_loss + 1'b1;
          end
        end
        default: begin
          r_state   <= S_ASSERT;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst_out   = r_pll_rst;
  assign sys_rst_out   = r_sys_rst;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_lock_loss;
  assign timeout_cnt   = r_timeout;
  assign o_dbg_state   = r_state;

endmodule
